ps2_note_mapper: RTL and testbench

- PS/2 keyboard receiver plus scancode decoder that converts make/break codes into a held-note bitmap and a current-note index for the audio tone generator.
- Generalises the single 8-bit key-to-audio link to NUM_KEYS channels with a configurable scancode map.
- Adds break-code and release tracking, last-pressed priority, parity/timeout error handling and overflow recovery.
- Sits between the PS2_CLK/PS2_DAT pins and the audio top level, replacing direct LED/switch-style key wiring.

---
 rtl/ps2_note_mapper_if.sv | 24 ++
 rtl/ps2_note_mapper.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_note_mapper.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_note_mapper_if.sv
// Pin-side and note-side signal bundle for ps2_note_mapper.
// The mapper is the master; the audio side (and the PS/2 pad driver in test) is the slave.
interface ps2_note_mapper_if #(
    parameter int NUM_KEYS = 8,
    parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
    logic                PS2_CLK;
    logic                PS2_DAT;
    logic [NUM_KEYS-1:0] key_held;
    logic [IDX_W-1:0]    note_idx;
    logic                note_valid;
    logic                event_strobe;
    logic                frame_error;

    modport master (
        input  PS2_CLK, PS2_DAT,
        output key_held, note_idx, note_valid, event_strobe, frame_error
    );

    modport slave (
        output PS2_CLK, PS2_DAT,
        input  key_held, note_idx, note_valid, event_strobe, frame_error
    );
endinterface

// File: rtl/ps2_note_mapper.sv
// PS/2 frame receiver and make/break decoder producing a held-note bitmap
// with last-pressed priority for the tone generator.
module ps2_note_mapper #(
    parameter int                    NUM_KEYS       = 8,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h42, 8'h3B, 8'h33, 8'h34,
                                                       8'h2B, 8'h23, 8'h1B, 8'h1C},
    parameter int                    TIMEOUT_CYCLES = 50000,
    parameter int                    IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    ps2_note_mapper_if.master  bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } dec_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic             clk_meta_r, clk_sync_r, clk_prev_r;
    logic             dat_meta_r, dat_sync_r;
    logic [3:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic             rx_valid_r, rx_err_r;
    logic [7:0]       rx_byte_r;
    logic             fall_s, timeout_s;

    dec_state_t          state_r, state_nxt;
    logic [NUM_KEYS-1:0] key_held_r, held_nxt, match_s, remain_s;
    logic [IDX_W-1:0]    note_idx_r, idx_nxt, hit_idx_s, top_idx_s;
    logic                note_valid_r, event_strobe_r, strobe_nxt, hit_s;

    assign fall_s    = clk_prev_r & ~clk_sync_r;
    assign timeout_s = (bit_cnt_r != 4'd0) && !fall_s && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronisers; the clock line idles high so it resets to 1.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= bus.PS2_CLK;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= bus.PS2_DAT;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Frame receiver: bit counter, shift register, stop/parity check and idle timeout.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            to_cnt_r   <= '0;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            rx_byte_r  <= 8'h00;
        end else begin
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            if (fall_s) begin
                to_cnt_r <= '0;
                case (bit_cnt_r)
                    4'd0: bit_cnt_r <= dat_sync_r ? 4'd0 : 4'd1;
                    4'd9: begin
                        parity_r  <= dat_sync_r;
                        bit_cnt_r <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt_r <= 4'd0;
                        if (odd_parity_ok(shift_r, parity_r) && dat_sync_r) begin
                            rx_valid_r <= 1'b1;
                            rx_byte_r  <= shift_r;
                        end else begin
                            rx_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        shift_r   <= {dat_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                endcase
            end else if (timeout_s) begin
                bit_cnt_r <= 4'd0;
                to_cnt_r  <= '0;
                rx_err_r  <= 1'b1;
            end else if (bit_cnt_r != 4'd0) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    // Key lookup (lowest index wins) and highest remaining key after a release.
    always_comb begin
        hit_idx_s = '0;
        top_idx_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_s[i] = (rx_byte_r == KEY_CODES[8*i +: 8]);
        end
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            hit_idx_s = match_s[i] ? IDX_W'(i) : hit_idx_s;
        end
        hit_s    = |match_s;
        remain_s = key_held_r & ~(NUM_KEYS'(1) << hit_idx_s);
        for (int i = 0; i < NUM_KEYS; i++) begin
            top_idx_s = remain_s[i] ? IDX_W'(i) : top_idx_s;
        end
    end

    // Decoder next state and next note outputs.
    always_comb begin
        state_nxt  = state_r;
        held_nxt   = key_held_r;
        idx_nxt    = note_idx_r;
        strobe_nxt = 1'b0;
        if (rx_err_r) begin
            state_nxt = ST_IDLE;
        end else if (rx_valid_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_byte_r == 8'hF0) begin
                        state_nxt = ST_BREAK;
                    end else if (rx_byte_r == 8'hE0) begin
                        state_nxt = ST_EXT;
                    end else if (hit_s) begin
                        if (!key_held_r[hit_idx_s]) begin
                            held_nxt[hit_idx_s] = 1'b1;
                            idx_nxt             = hit_idx_s;
                            strobe_nxt          = 1'b1;
                        end else begin
                            strobe_nxt = 1'b0;
                        end
                    end else if (rx_byte_r == 8'h00 || rx_byte_r == 8'hFF) begin
                        held_nxt   = '0;
                        idx_nxt    = '0;
                        strobe_nxt = |key_held_r;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    state_nxt = ST_IDLE;
                    if (hit_s && key_held_r[hit_idx_s]) begin
                        held_nxt   = remain_s;
                        strobe_nxt = 1'b1;
                        if (remain_s == '0) begin
                            idx_nxt = '0;
                        end else if (hit_idx_s == note_idx_r) begin
                            idx_nxt = top_idx_s;
                        end else begin
                            idx_nxt = note_idx_r;
                        end
                    end else begin
                        strobe_nxt = 1'b0;
                    end
                end
                ST_EXT:       state_nxt = (rx_byte_r == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                ST_EXT_BREAK: state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Decoder state and registered note outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            key_held_r     <= '0;
            note_idx_r     <= '0;
            note_valid_r   <= 1'b0;
            event_strobe_r <= 1'b0;
        end else begin
            state_r        <= state_nxt;
            key_held_r     <= held_nxt;
            note_idx_r     <= idx_nxt;
            note_valid_r   <= |held_nxt;
            event_strobe_r <= strobe_nxt;
        end
    end

    assign bus.key_held     = key_held_r;
    assign bus.note_idx     = note_idx_r;
    assign bus.note_valid   = note_valid_r;
    assign bus.event_strobe = event_strobe_r;
    assign bus.frame_error  = rx_err_r;
endmodule

// File: tb/tb_ps2_note_mapper.sv
// Randomised and directed bench for ps2_note_mapper against a key-event reference model.
module tb_ps2_note_mapper;
    localparam int NK   = 8;
    localparam int IW   = 3;
    localparam int TO   = 300;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    ps2_note_mapper_if #(.NUM_KEYS(NK), .IDX_W(IW)) bus ();

    ps2_note_mapper #(.NUM_KEYS(NK), .TIMEOUT_CYCLES(TO), .IDX_W(IW)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;

    // Model state: keys in press order, scancode map and pending prefix bytes.
    logic [7:0]    key_codes [NK] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    logic [NK-1:0] m_held;
    int            m_idx;
    bit            after_f0, after_e0, after_e0f0;

    always @(negedge clk) begin
        if (bus.event_strobe) strobe_cnt <= strobe_cnt + 1;
        if (bus.frame_error)  ferr_cnt   <= ferr_cnt + 1;
    end

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < NK; i++) if (key_codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b, input bit bad);
        logic p;
        p = (~^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic model_clear();
        m_held = '0; m_idx = 0;
        after_f0 = 0; after_e0 = 0; after_e0f0 = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit strobe);
        int k;
        strobe = 0;
        k = lookup(b);
        if (after_e0f0) begin
            after_e0f0 = 0;
        end else if (after_e0) begin
            after_e0 = 0;
            after_e0f0 = (b == 8'hF0);
        end else if (after_f0) begin
            after_f0 = 0;
            if (k >= 0 && m_held[k]) begin
                m_held[k] = 1'b0;
                strobe = 1;
                if (m_held == '0) m_idx = 0;
                else if (k == m_idx) begin
                    for (int j = 0; j < NK; j++) if (m_held[j]) m_idx = j;
                end
            end
        end else if (b == 8'hF0) after_f0 = 1;
        else if (b == 8'hE0) after_e0 = 1;
        else if (k >= 0) begin
            if (!m_held[k]) begin
                m_held[k] = 1'b1; m_idx = k; strobe = 1;
            end
        end else if (b == 8'h00 || b == 8'hFF) begin
            strobe = (m_held != '0);
            m_held = '0; m_idx = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.PS2_DAT = bits[i];
            repeat (HALF) @(negedge clk);
            bus.PS2_CLK = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.PS2_CLK = 1'b1;
        end
    endtask

    // Full frame; checks the error pulse at T+1 and the note update at T+2.
    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic [10:0]   bits;
        logic [NK-1:0] old_held;
        bit            st;
        bits = frame_of(b, bad);
        old_held = m_held;
        if (bad) begin
            st = 0; after_f0 = 0; after_e0 = 0; after_e0f0 = 0;
        end else begin
            model_byte(b, st);
        end
        send_bits(bits, 10);
        @(negedge clk) bus.PS2_DAT = bits[10];
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.key_held !== old_held) begin
            miscompares++;
            $display("FAIL t1_held byte=%h got=%h exp=%h", b, bus.key_held, old_held);
        end
        vectors++;
        if (bus.frame_error !== bad) begin
            miscompares++;
            $display("FAIL t1_frame_error byte=%h got=%b exp=%b", b, bus.frame_error, bad);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.key_held !== m_held) begin
            miscompares++;
            $display("FAIL t2_held byte=%h got=%h exp=%h", b, bus.key_held, m_held);
        end
        vectors++;
        if (bus.note_idx !== IW'(m_idx)) begin
            miscompares++;
            $display("FAIL t2_idx byte=%h got=%0d exp=%0d", b, bus.note_idx, m_idx);
        end
        vectors++;
        if (bus.note_valid !== (m_held != '0)) begin
            miscompares++;
            $display("FAIL t2_valid byte=%h got=%b exp=%b", b, bus.note_valid, (m_held != '0));
        end
        vectors++;
        if (bus.event_strobe !== st) begin
            miscompares++;
            $display("FAIL t2_strobe byte=%h got=%b exp=%b", b, bus.event_strobe, st);
        end
        vectors++;
        if (bus.frame_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t2_frame_error_width byte=%h got=%b exp=0", b, bus.frame_error);
        end
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.key_held, bus.note_idx, bus.note_valid, bus.event_strobe, bus.frame_error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got held=%h idx=%0d v=%b s=%b e=%b exp=all 0",
                     bus.key_held, bus.note_idx, bus.note_valid, bus.event_strobe, bus.frame_error);
        end
    endtask

    task automatic test_make_break();
        int s0;
        do_reset();
        s0 = strobe_cnt;
        send_frame(8'h1C, 0);
        send_frame(8'h23, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h23, 0);
        vectors++;
        if (strobe_cnt - s0 !== 3) begin
            miscompares++;
            $display("FAIL make_break_strobes got=%0d exp=3", strobe_cnt - s0);
        end
    endtask

    task automatic test_typematic();
        int s0;
        do_reset();
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) send_frame(8'h1C, 0);
        vectors++;
        if (strobe_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL typematic_strobes got=%0d exp=1", strobe_cnt - s0);
        end
    endtask

    task automatic test_errors();
        int e0;
        do_reset();
        send_frame(8'h1C, 1);
        e0 = ferr_cnt;
        send_bits(frame_of(8'h1B, 0), 4);
        repeat (TO + 50) @(negedge clk);
        vectors++;
        if (ferr_cnt - e0 !== 1) begin
            miscompares++;
            $display("FAIL timeout_frame_error got=%0d exp=1", ferr_cnt - e0);
        end
        after_f0 = 0; after_e0 = 0; after_e0f0 = 0;
        send_frame(8'h1B, 0);
        vectors++;
        if (bus.key_held !== 8'h02) begin
            miscompares++;
            $display("FAIL after_timeout_held got=%h exp=02", bus.key_held);
        end
    endtask

    task automatic test_ext_overflow();
        do_reset();
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);
        send_frame(8'h42, 0);
        send_frame(8'h34, 0);
        send_frame(8'hFF, 0);
        send_frame(8'h00, 0);
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(8'h1C, 0);
        send_frame(8'h42, 0);
        send_bits(frame_of(8'h23, 0), 5);
        @(negedge clk) bus.PS2_CLK = 1'b0;
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.key_held, bus.note_idx, bus.note_valid, bus.event_strobe} !== '0) begin
            miscompares++;
            $display("FAIL midframe_reset got held=%h idx=%0d v=%b s=%b exp=all 0",
                     bus.key_held, bus.note_idx, bus.note_valid, bus.event_strobe);
        end
        do_reset();
        send_frame(8'h42, 0);
        vectors++;
        if (bus.key_held !== 8'h80 || bus.note_idx !== 3'd7) begin
            miscompares++;
            $display("FAIL post_reset_42 got held=%h idx=%0d exp=80/7", bus.key_held, bus.note_idx);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [7:0] b;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 13);
            if (sel <= 6)       b = key_codes[$urandom_range(0, NK - 1)];
            else if (sel <= 9)  b = 8'hF0;
            else if (sel == 10) b = 8'hE0;
            else if (sel == 11) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            else                b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        model_clear();
        test_reset();
        send_frame(8'h1C, 0);
        test_make_break();
        test_typematic();
        test_errors();
        test_ext_overflow();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
